// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between the execute
// stage (id 0) and the address/PC-update unit (id 1).
module alu_share_arbiter #(
    parameter int WIDTH  = 64,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [WIDTH-1:0]  req0_x,
    input  logic [WIDTH-1:0]  req0_y,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [WIDTH-1:0]  req1_x,
    input  logic [WIDTH-1:0]  req1_y,
    output logic [WIDTH-1:0]  alu_x,
    output logic [WIDTH-1:0]  alu_y,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [WIDTH-1:0]  alu_final,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [WIDTH-1:0]  resp_data,
    output logic              resp_err
);

    localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(4'b0001);
    localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(4'b0110);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              last_grant;
    logic              gnt_id;
    logic [CTRL_W-1:0] op_ctrl;
    logic [WIDTH-1:0]  op_x;
    logic [WIDTH-1:0]  op_y;
    logic              pick1;
    logic              grant0;
    logic              grant1;
    logic              illegal;

    assign illegal = !(op_ctrl inside {OP_AND, OP_OR, OP_ADD, OP_SUB});

    // Requester 1 wins when alone, or when both ask and 0 went last.
    assign pick1 = req1_valid & (~req0_valid | ~last_grant);

    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        alu_x     = '0;
        alu_y     = '0;
        alu_ctrl  = '0;
        unique case (state)
            IDLE: begin
                if (req0_valid | req1_valid) begin
                    grant1    = pick1;
                    grant0    = ~pick1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                alu_x     = op_x;
                alu_y     = op_y;
                alu_ctrl  = op_ctrl;
                state_nxt = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (reset) begin
            grant0   = 1'b0;
            grant1   = 1'b0;
            alu_x    = '0;
            alu_y    = '0;
            alu_ctrl = '0;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            gnt_id     <= 1'b0;
            op_ctrl    <= '0;
            op_x       <= '0;
            op_y       <= '0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (grant0 | grant1) begin
                op_ctrl    <= grant1 ? req1_ctrl : req0_ctrl;
                op_x       <= grant1 ? req1_x : req0_x;
                op_y       <= grant1 ? req1_y : req0_y;
                gnt_id     <= grant1;
                last_grant <= grant1;
            end
            if (state == ISSUE) begin
                resp_valid <= 1'b1;
                resp_id    <= gnt_id;
                resp_err   <= illegal;
                resp_data  <= illegal ? '0 : alu_final;
            end
            if (state == RESP && resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: scoreboard queue filled by the
// stimulus, drained by a monitor on every response handshake.
module tb_alu_share_arbiter;

    localparam int W = 64;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid;
    logic         req0_ready;
    logic [C-1:0] req0_ctrl;
    logic [W-1:0] req0_x;
    logic [W-1:0] req0_y;
    logic         req1_valid;
    logic         req1_ready;
    logic [C-1:0] req1_ctrl;
    logic [W-1:0] req1_x;
    logic [W-1:0] req1_y;
    logic [W-1:0] alu_x;
    logic [W-1:0] alu_y;
    logic [C-1:0] alu_ctrl;
    logic [W-1:0] alu_final;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [W-1:0] resp_data;
    logic         resp_err;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_resp   = 0;
    logic g;

    localparam logic [W-1:0] ONES = {W{1'b1}};

    alu_share_arbiter #(.WIDTH(W), .CTRL_W(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_ctrl  (req0_ctrl),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_ctrl  (req1_ctrl),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_ctrl   (alu_ctrl),
        .alu_final  (alu_final),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // ALU model; illegal codes give junk the arbiter must mask to 0.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_final = alu_x & alu_y;
            4'b0001: alu_final = alu_x | alu_y;
            4'b0010: alu_final = alu_x + alu_y;
            4'b0110: alu_final = alu_x - alu_y;
            default: alu_final = 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    end

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic id, input logic [W-1:0] d,
                        input logic err);
        exp_t x;
        x.id   = id;
        x.data = d;
        x.err  = err;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output logic id);
        bit got = 1'b0;
        id = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (req0_ready | req1_ready) begin
                got = 1'b1;
                id  = req1_ready;
            end else begin
                tick();
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL grant_timeout: got no ready, required a grant");
        end
    endtask

    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            n_resp++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: got id %0d data %h, required none",
                         resp_id, resp_data);
            end else begin
                e = sb.pop_front();
                chk("resp_id", W'(resp_id), W'(e.id));
                chk("resp_data", resp_data, e.data);
                chk("resp_err", W'(resp_err), W'(e.err));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset      = 1'b1;
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        req0_ctrl  = 4'b0000;
        req0_x     = 64'h1334_5678_4ACB_CF77;
        req0_y     = 64'hFEEC_B209_8755_D301;
        req1_valid = 1'b1;
        req1_ctrl  = 4'b0001;
        req1_x     = 64'hF0F0_0000_0000_00FF;
        req1_y     = 64'h0F0F_0000_1234_0000;

        // reset held with requests pending
        repeat (2) begin
            tick();
            chk("rst_req0_ready", W'(req0_ready), 0);
            chk("rst_resp_valid", W'(resp_valid), 0);
            chk("rst_resp_data", resp_data, 0);
        end
        chk("rst_alu_ctrl", W'(alu_ctrl), 0);

        // first grant after reset goes to requester 0
        reset = 1'b0;
        #1;
        chk("first_grant_r0", W'(req0_ready), 1);
        chk("first_grant_r1", W'(req1_ready), 0);
        push(1'b0, 64'h1224_1208_0241_C301, 1'b0);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("ready_pulse", W'(req0_ready), 0);
        chk("issue_ctrl", W'(alu_ctrl), 0);
        chk("issue_x", alu_x, 64'h1334_5678_4ACB_CF77);
        chk("issue_y", alu_y, 64'hFEEC_B209_8755_D301);
        chk("issue_no_valid", W'(resp_valid), 0);
        tick();
        chk("latency_valid", W'(resp_valid), 1);
        chk("resp_alu_idle", alu_x, 0);
        tick();
        #1;
        chk("rr_grant1", W'(req1_ready), 1);
        push(1'b1, 64'hFFFF_0000_1234_00FF, 1'b0);
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();

        // contention: strict alternation starting with 0
        req0_ctrl  = 4'b0010;
        req0_x     = 64'd1;
        req0_y     = 64'd1;
        req1_ctrl  = 4'b0110;
        req1_x     = 64'd0;
        req1_y     = 64'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(g);
            chk("contention_order", W'(g), W'(k % 2));
            if (k % 2 == 0) push(1'b0, 64'd2, 1'b0);
            else            push(1'b1, ONES, 1'b0);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) tick();

        // backpressure in RESP, with wrap-around add
        resp_ready = 1'b0;
        req0_ctrl  = 4'b0010;
        req0_x     = ONES;
        req0_y     = 64'd2;
        req0_valid = 1'b1;
        wait_grant(g);
        chk("bp_grant", W'(g), 0);
        push(1'b0, 64'd1, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_ctrl  = 4'b1111;
        req1_x     = ONES;
        req1_y     = ONES;
        req1_valid = 1'b1;
        tick();
        repeat (5) begin
            #1;
            chk("bp_valid", W'(resp_valid), 1);
            chk("bp_data", resp_data, 64'd1);
            chk("bp_id", W'(resp_id), 0);
            chk("bp_no_grant", W'(req1_ready), 0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_no_grant_rel", W'(req1_ready), 0);
        tick();
        #1;
        chk("bp_valid_drop", W'(resp_valid), 0);
        chk("bp_data_hold", resp_data, 64'd1);
        chk("bp_idle_grant", W'(req1_ready), 1);

        // illegal code from requester 1
        push(1'b1, 64'd0, 1'b1);
        tick();
        req1_valid = 1'b0;
        repeat (3) tick();

        // reset while in ISSUE drops the operation
        req0_ctrl  = 4'b0010;
        req0_x     = 64'd1;
        req0_y     = 64'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_ctrl  = 4'b0110;
        req1_x     = 64'd0;
        req1_y     = 64'd1;
        wait_grant(g);
        chk("mid_grant", W'(g), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("mid_resp_valid", W'(resp_valid), 0);
        chk("mid_resp_id", W'(resp_id), 0);
        chk("mid_resp_err", W'(resp_err), 0);
        chk("mid_resp_data", resp_data, 0);
        chk("mid_alu_ctrl", W'(alu_ctrl), 0);
        chk("mid_ready", W'({req1_ready, req0_ready}), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_r0", W'(req0_ready), 1);
        chk("post_rst_r1", W'(req1_ready), 0);
        push(1'b0, 64'd2, 1'b0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) tick();

        chk("sb_empty", W'(sb.size()), 0);
        chk("resp_count", W'(n_resp), 9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
